// File: rtl/mshr_refill_arb.sv
// ---------------------------------------------------------------------------
// mshr_refill_arb
//
// Round-robin arbiter and refill staging register between the dcache MSHR
// entries and the data/tag array write port. While idle, it picks one entry
// whose refill data has returned, starting the scan at the round-robin
// pointer. It latches that entry's line address, ROB id, refill line and
// index, and presents them to the array with a valid/ready handshake. When
// the array accepts, a one-hot grant pulse tells the entry to leave its
// refill state. The pointer then moves to the entry after the winner.
//
// Ports:
//   clock             - clock
//   reset_n           - asynchronous, active-low reset
//   entry_rdy2refill  - per-entry "data returned, ready to refill" flag
//   entry_paddr       - per-entry line address, entry i at [i*PADDR_W +: PADDR_W]
//   entry_robid       - per-entry oldest ROB id, same slicing
//   entry_refilldata  - per-entry 512-bit refill line, same slicing
//   win_refill_arb    - one-hot grant pulse in the cycle the refill is accepted
//   refill_valid      - refill request valid
//   refill_ready      - array accepts the refill this cycle
//   refill_paddr      - latched line address
//   refill_robid      - latched ROB id
//   refill_mshrid     - index of the selected entry
//   refill_data       - latched refill line
//   refill_cnt        - number of accepted refills (wraps at 2^32)
// ---------------------------------------------------------------------------
module mshr_refill_arb #(
    parameter int MSHR_NUM     = 4,
    parameter int MSHR_NUM_LOG = 2,
    parameter int PADDR_W      = 64,
    parameter int ROBID_W      = 7
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [MSHR_NUM-1:0]         entry_rdy2refill,
    input  logic [MSHR_NUM*PADDR_W-1:0] entry_paddr,
    input  logic [MSHR_NUM*ROBID_W-1:0] entry_robid,
    input  logic [MSHR_NUM*512-1:0]     entry_refilldata,
    output logic [MSHR_NUM-1:0]         win_refill_arb,
    output logic                        refill_valid,
    input  logic                        refill_ready,
    output logic [PADDR_W-1:0]          refill_paddr,
    output logic [ROBID_W-1:0]          refill_robid,
    output logic [MSHR_NUM_LOG-1:0]     refill_mshrid,
    output logic [511:0]                refill_data,
    output logic [31:0]                 refill_cnt
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]              state_q,   state_d;
    logic [MSHR_NUM_LOG-1:0] rr_ptr_q,  rr_ptr_d;
    logic [PADDR_W-1:0]      paddr_q,   paddr_d;
    logic [ROBID_W-1:0]      robid_q,   robid_d;
    logic [MSHR_NUM_LOG-1:0] mshrid_q,  mshrid_d;
    logic [511:0]            data_q,    data_d;
    logic [31:0]             refill_cnt_q, refill_cnt_d;

    logic                    sel_found;
    logic [MSHR_NUM_LOG-1:0] sel_idx;
    logic [MSHR_NUM_LOG-1:0] scan_idx;

    // Round-robin scan: the first set flag at rr_ptr, rr_ptr+1, ... wins.
    // MSHR_NUM is a power of two, so the index addition wraps by truncation.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < MSHR_NUM; k++) begin
            scan_idx = rr_ptr_q + MSHR_NUM_LOG'(k);
            if (!sel_found && entry_rdy2refill[scan_idx]) begin
                sel_found = 1'b1;
                sel_idx   = scan_idx;
            end
        end
    end

    // Output registers load only on selection in IDLE; in BUSY they are frozen
    // and the handshake cycle returns to IDLE without making a new selection.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        paddr_d      = paddr_q;
        robid_d      = robid_q;
        mshrid_d     = mshrid_q;
        data_d       = data_q;
        refill_cnt_d = refill_cnt_q;
        if (state_q == IDLE) begin
            if (sel_found) begin
                state_d  = BUSY;
                paddr_d  = entry_paddr[int'(sel_idx)*PADDR_W +: PADDR_W];
                robid_d  = entry_robid[int'(sel_idx)*ROBID_W +: ROBID_W];
                data_d   = entry_refilldata[int'(sel_idx)*512 +: 512];
                mshrid_d = sel_idx;
            end
        end else if (refill_ready) begin
            state_d      = IDLE;
            rr_ptr_d     = mshrid_q + MSHR_NUM_LOG'(1);
            refill_cnt_d = refill_cnt_q + 32'd1;
        end
    end

    // All architectural state clears asynchronously, so a pending refill is
    // dropped the moment reset asserts.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            paddr_q      <= '0;
            robid_q      <= '0;
            mshrid_q     <= '0;
            data_q       <= '0;
            refill_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            paddr_q      <= paddr_d;
            robid_q      <= robid_d;
            mshrid_q     <= mshrid_d;
            data_q       <= data_d;
            refill_cnt_q <= refill_cnt_d;
        end
    end

    // Grant is combinational in the handshake cycle. Since valid is the BUSY
    // state itself, ready while idle can never produce a pulse.
    always_comb begin
        win_refill_arb = '0;
        if (state_q == BUSY && refill_ready) begin
            win_refill_arb[mshrid_q] = 1'b1;
        end
    end

    assign refill_valid  = (state_q == BUSY);
    assign refill_paddr  = paddr_q;
    assign refill_robid  = robid_q;
    assign refill_mshrid = mshrid_q;
    assign refill_data   = data_q;
    assign refill_cnt    = refill_cnt_q;

endmodule

// File: tb/tb_mshr_refill_arb.sv
// ---------------------------------------------------------------------------
// tb_mshr_refill_arb
//
// Directed bench for the MSHR refill arbiter. Inputs change on the falling
// edge and outputs are sampled 1 time unit later. Each scenario task carries
// its own hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_mshr_refill_arb;

    localparam int N  = 4;
    localparam int L  = 2;
    localparam int PW = 64;
    localparam int RW = 7;

    logic            clock = 1'b0;
    logic            reset_n;
    logic [N-1:0]    rdy;
    logic [N*PW-1:0] paddr;
    logic [N*RW-1:0] robid;
    logic [N*512-1:0] data;
    logic [N-1:0]    win;
    logic            valid;
    logic            ready;
    logic [PW-1:0]   rpaddr;
    logic [RW-1:0]   rrobid;
    logic [L-1:0]    rid;
    logic [511:0]    rdata;
    logic [31:0]     rcnt;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    mshr_refill_arb #(.MSHR_NUM(N), .MSHR_NUM_LOG(L), .PADDR_W(PW), .ROBID_W(RW)) dut (
        .clock(clock), .reset_n(reset_n),
        .entry_rdy2refill(rdy), .entry_paddr(paddr), .entry_robid(robid),
        .entry_refilldata(data), .win_refill_arb(win), .refill_valid(valid),
        .refill_ready(ready), .refill_paddr(rpaddr), .refill_robid(rrobid),
        .refill_mshrid(rid), .refill_data(rdata), .refill_cnt(rcnt)
    );

    // Per-entry patterns derived from a base word so every entry is distinct.
    function automatic logic [PW-1:0] patPaddr(input int i, input logic [31:0] base);
        return {32'h0, base} + 64'(i) * 64'h40;
    endfunction

    function automatic logic [RW-1:0] patRobid(input int i, input logic [31:0] base);
        return 7'(i * 3 + 1) + base[30:24];
    endfunction

    function automatic logic [511:0] patData(input int i, input logic [31:0] base);
        return {16{base ^ 32'(i * 32'h0101_0101)}};
    endfunction

    task automatic loadEntries(input logic [31:0] base);
        for (int i = 0; i < N; i++) begin
            paddr[i*PW +: PW]   = patPaddr(i, base);
            robid[i*RW +: RW]   = patRobid(i, base);
            data[i*512 +: 512]  = patData(i, base);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; rdy = '0; paddr = '0; robid = '0; data = '0; ready = 1'b0;
        @(negedge clock); #1;
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid got %b want 0", valid); end
        vectors++; if (rcnt !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_cnt got %h want 0", rcnt); end
        vectors++; if (win !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_win got %b want 0000", win); end
        vectors++; if ({rpaddr, rrobid, rid} !== '0) begin miscompares++; $display("[TB] FAIL reset_regs got %h/%h/%h want 0", rpaddr, rrobid, rid); end
        vectors++; if (rdata !== '0) begin miscompares++; $display("[TB] FAIL reset_data got nonzero want 0"); end
        vectors++; if (dut.rr_ptr_q !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_rrptr got %0d want 0", dut.rr_ptr_q); end
        @(negedge clock); reset_n = 1'b1;
    endtask

    task automatic test_simultaneous;
        int order [3] = '{0, 1, 3};
        @(negedge clock);
        loadEntries(32'h1000_0000); rdy = 4'b1011; ready = 1'b1;
        #1;
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("[TB] FAIL sim_idle_valid got %b want 0", valid); end
        foreach (order[k]) begin
            @(negedge clock); #1;
            vectors++; if (valid !== 1'b1) begin miscompares++; $display("[TB] FAIL sim_valid[%0d] got %b want 1", k, valid); end
            vectors++; if (rid !== L'(order[k])) begin miscompares++; $display("[TB] FAIL sim_mshrid[%0d] got %0d want %0d", k, rid, order[k]); end
            vectors++; if (rpaddr !== patPaddr(order[k], 32'h1000_0000)) begin miscompares++; $display("[TB] FAIL sim_paddr[%0d] got %h want %h", k, rpaddr, patPaddr(order[k], 32'h1000_0000)); end
            vectors++; if (rrobid !== patRobid(order[k], 32'h1000_0000)) begin miscompares++; $display("[TB] FAIL sim_robid[%0d] got %h want %h", k, rrobid, patRobid(order[k], 32'h1000_0000)); end
            vectors++; if (rdata !== patData(order[k], 32'h1000_0000)) begin miscompares++; $display("[TB] FAIL sim_data[%0d] got %h want %h", k, rdata[31:0], patData(order[k], 32'h1000_0000) & 512'hFFFF_FFFF); end
            vectors++; if (win !== N'(1) << order[k]) begin miscompares++; $display("[TB] FAIL sim_win[%0d] got %b want %b", k, win, N'(1) << order[k]); end
            rdy[order[k]] = 1'b0;
            @(negedge clock); #1;
            vectors++; if (valid !== 1'b0 || win !== 4'b0000) begin miscompares++; $display("[TB] FAIL sim_gap[%0d] got valid %b win %b want 0 0000", k, valid, win); end
        end
        vectors++; if (dut.rr_ptr_q !== 2'd0) begin miscompares++; $display("[TB] FAIL sim_rrptr got %0d want 0", dut.rr_ptr_q); end
        vectors++; if (rcnt !== 32'd3) begin miscompares++; $display("[TB] FAIL sim_cnt got %0d want 3", rcnt); end
    endtask

    task automatic test_single;
        @(negedge clock);
        paddr[2*PW +: PW]  = 64'h8000_0040;
        robid[2*RW +: RW]  = 7'd5;
        data[2*512 +: 512] = {16{32'hA5A5_5A5A}};
        rdy = 4'b0100; ready = 1'b1;
        #1;
        vectors++; if (valid !== 1'b0 || win !== 4'b0000) begin miscompares++; $display("[TB] FAIL single_idle got valid %b win %b want 0 0000", valid, win); end
        @(negedge clock); #1;
        vectors++; if (valid !== 1'b1) begin miscompares++; $display("[TB] FAIL single_valid got %b want 1", valid); end
        vectors++; if (rpaddr !== 64'h8000_0040) begin miscompares++; $display("[TB] FAIL single_paddr got %h want 80000040", rpaddr); end
        vectors++; if (rrobid !== 7'd5) begin miscompares++; $display("[TB] FAIL single_robid got %0d want 5", rrobid); end
        vectors++; if (rid !== 2'd2) begin miscompares++; $display("[TB] FAIL single_mshrid got %0d want 2", rid); end
        vectors++; if (rdata !== {16{32'hA5A5_5A5A}}) begin miscompares++; $display("[TB] FAIL single_data got %h want a5a55a5a", rdata[31:0]); end
        vectors++; if (win !== 4'b0100) begin miscompares++; $display("[TB] FAIL single_win got %b want 0100", win); end
        rdy = 4'b0000;
        @(negedge clock); #1;
        vectors++; if (valid !== 1'b0 || win !== 4'b0000) begin miscompares++; $display("[TB] FAIL single_after got valid %b win %b want 0 0000", valid, win); end
        vectors++; if (rcnt !== 32'd4) begin miscompares++; $display("[TB] FAIL single_cnt got %0d want 4", rcnt); end
        vectors++; if (dut.rr_ptr_q !== 2'd3) begin miscompares++; $display("[TB] FAIL single_rrptr got %0d want 3", dut.rr_ptr_q); end
    endtask

    task automatic test_wraparound;
        @(negedge clock);
        loadEntries(32'h2000_0000); rdy = 4'b1001; ready = 1'b1;
        @(negedge clock); #1;
        vectors++; if (rid !== 2'd3 || win !== 4'b1000) begin miscompares++; $display("[TB] FAIL wrap_first got id %0d win %b want 3 1000", rid, win); end
        vectors++; if (rpaddr !== patPaddr(3, 32'h2000_0000)) begin miscompares++; $display("[TB] FAIL wrap_paddr3 got %h want %h", rpaddr, patPaddr(3, 32'h2000_0000)); end
        rdy[3] = 1'b0;
        @(negedge clock); #1;
        vectors++; if (valid !== 1'b0 || dut.rr_ptr_q !== 2'd0) begin miscompares++; $display("[TB] FAIL wrap_gap got valid %b ptr %0d want 0 0", valid, dut.rr_ptr_q); end
        @(negedge clock); #1;
        vectors++; if (rid !== 2'd0 || win !== 4'b0001) begin miscompares++; $display("[TB] FAIL wrap_second got id %0d win %b want 0 0001", rid, win); end
        vectors++; if (rpaddr !== patPaddr(0, 32'h2000_0000)) begin miscompares++; $display("[TB] FAIL wrap_paddr0 got %h want %h", rpaddr, patPaddr(0, 32'h2000_0000)); end
        rdy[0] = 1'b0;
        @(negedge clock); #1;
        vectors++; if (rcnt !== 32'd6 || dut.rr_ptr_q !== 2'd1) begin miscompares++; $display("[TB] FAIL wrap_end got cnt %0d ptr %0d want 6 1", rcnt, dut.rr_ptr_q); end
    endtask

    task automatic test_backpressure;
        @(negedge clock);
        loadEntries(32'h3000_0000); rdy = 4'b0010; ready = 1'b0;
        @(negedge clock);
        for (int c = 0; c < 5; c++) begin
            #1;
            vectors++; if (valid !== 1'b1 || rid !== 2'd1 || win !== 4'b0000) begin miscompares++; $display("[TB] FAIL bp_hold[%0d] got valid %b id %0d win %b want 1 1 0000", c, valid, rid, win); end
            vectors++; if (rpaddr !== patPaddr(1, 32'h3000_0000) || rdata !== patData(1, 32'h3000_0000)) begin miscompares++; $display("[TB] FAIL bp_frozen[%0d] got %h want %h", c, rpaddr, patPaddr(1, 32'h3000_0000)); end
            paddr[PW +: PW]  = 64'hDEAD_0000 + 64'(c);
            data[512 +: 512] = ~data[512 +: 512];
            rdy = 4'b1011;
            @(negedge clock);
        end
        ready = 1'b1;
        #1;
        vectors++; if (win !== 4'b0010) begin miscompares++; $display("[TB] FAIL bp_win got %b want 0010", win); end
        vectors++; if (rpaddr !== patPaddr(1, 32'h3000_0000)) begin miscompares++; $display("[TB] FAIL bp_paddr got %h want %h", rpaddr, patPaddr(1, 32'h3000_0000)); end
        rdy = 4'b0000;
        @(negedge clock); #1;
        vectors++; if (valid !== 1'b0 || win !== 4'b0000 || rcnt !== 32'd7) begin miscompares++; $display("[TB] FAIL bp_end got valid %b win %b cnt %0d want 0 0000 7", valid, win, rcnt); end
        vectors++; if (dut.rr_ptr_q !== 2'd2) begin miscompares++; $display("[TB] FAIL bp_rrptr got %0d want 2", dut.rr_ptr_q); end
    endtask

    task automatic test_reset_mid_busy;
        @(negedge clock);
        loadEntries(32'h4000_0000); rdy = 4'b1000; ready = 1'b0;
        @(negedge clock); #1;
        vectors++; if (valid !== 1'b1 || rid !== 2'd3) begin miscompares++; $display("[TB] FAIL rst_busy got valid %b id %0d want 1 3", valid, rid); end
        #2; reset_n = 1'b0; ready = 1'b1;
        #1;
        vectors++; if (valid !== 1'b0 || rcnt !== 32'd0 || dut.rr_ptr_q !== 2'd0) begin miscompares++; $display("[TB] FAIL rst_now got valid %b cnt %0d ptr %0d want 0 0 0", valid, rcnt, dut.rr_ptr_q); end
        vectors++; if (win !== 4'b0000 || rpaddr !== '0 || rid !== 2'd0) begin miscompares++; $display("[TB] FAIL rst_outs got win %b paddr %h id %0d want 0000 0 0", win, rpaddr, rid); end
        rdy = 4'b0000;
        @(negedge clock); reset_n = 1'b1;
        @(negedge clock); #1;
        vectors++; if (valid !== 1'b0 || win !== 4'b0000 || rcnt !== 32'd0) begin miscompares++; $display("[TB] FAIL rst_after got valid %b win %b cnt %0d want 0 0000 0", valid, win, rcnt); end
    endtask

    task automatic test_counter;
        @(negedge clock);
        force dut.refill_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.refill_cnt_q;
        #1;
        vectors++; if (rcnt !== 32'hFFFF_FFFF) begin miscompares++; $display("[TB] FAIL cnt_preset got %h want ffffffff", rcnt); end
        loadEntries(32'h5000_0000); rdy = 4'b0001; ready = 1'b1;
        @(negedge clock); #1;
        vectors++; if (win !== 4'b0001) begin miscompares++; $display("[TB] FAIL cnt_win got %b want 0001", win); end
        rdy = 4'b0000;
        @(negedge clock); #1;
        vectors++; if (rcnt !== 32'd0 || valid !== 1'b0) begin miscompares++; $display("[TB] FAIL cnt_wrap got cnt %h valid %b want 0 0", rcnt, valid); end
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_single();
        test_wraparound();
        test_backpressure();
        test_reset_mid_busy();
        test_counter();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout got no completion want finish before 100000");
        $fatal(1, "[TB] timeout");
    end

endmodule
